// File: rtl/instr_mem_sync_if.sv
// Load-port and fetch request/response bundle for the synchronous instruction memory.
interface instr_mem_sync_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  load_en;
   logic                  load_valid;
   logic [31:0]           load_data;
   logic                  load_last;
   logic                  load_ready;
   logic                  load_ovf;
   logic                  req_valid;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_ready;
   logic                  rsp_valid;
   logic [31:0]           rsp_instr;
   logic [ADDR_WIDTH-1:0] rsp_addr;
   logic [1:0]            rsp_err;
   logic                  rsp_ready;
   logic [1:0]            state;

   modport master (
      output load_en, load_valid, load_data, load_last, req_valid, req_addr, rsp_ready,
      input  load_ready, load_ovf, req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err, state
   );

   modport slave (
      input  load_en, load_valid, load_data, load_last, req_valid, req_addr, rsp_ready,
      output load_ready, load_ovf, req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err, state
   );
endinterface

// File: rtl/instr_mem_sync.sv
// Byte-addressed instruction memory: streaming program load, then 1-cycle
// registered fetch with misaligned / out-of-range flagging.
module instr_mem_sync #(
   parameter int          MEM_BYTES  = 1024,
   parameter int          ADDR_WIDTH = 32,
   parameter logic [31:0] NOP_WORD   = 32'h0000_0000,
   parameter bit          BIG_ENDIAN = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   instr_mem_sync_if.slave bus
);
   localparam int                    IW        = $clog2(MEM_BYTES);
   localparam int                    PW        = $clog2(MEM_BYTES + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_BYTES - 4);
   localparam logic [PW-1:0]         FULL      = PW'(MEM_BYTES);

   typedef enum logic [1:0] {EMPTY = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

   state_t                state_q, state_d;
   logic [7:0]            mem [MEM_BYTES];
   logic [PW-1:0]         wr_ptr;
   logic                  load_ovf_q;
   logic                  rsp_valid_q;
   logic [31:0]           rsp_instr_q;
   logic [ADDR_WIDTH-1:0] rsp_addr_q;
   logic [1:0]            rsp_err_q;
   logic                  load_ready_c, req_ready_c;
   logic                  beat, wr_en, req_acc, enter_load;
   logic                  mis, oor;
   logic [IW-3:0]         rd_widx;
   logic [31:0]           rd_word;

   always_comb begin
      state_d      = state_q;
      load_ready_c = 1'b0;
      req_ready_c  = 1'b0;
      case (state_q)
         EMPTY: if (bus.load_en) state_d = LOAD;
         LOAD: begin
            load_ready_c = 1'b1;
            if (bus.load_valid && bus.load_last) state_d = RUN;
         end
         RUN: begin
            req_ready_c = !bus.load_en && (!rsp_valid_q || bus.rsp_ready);
            // a reload waits until any pending response has been taken
            if (bus.load_en && (!rsp_valid_q || bus.rsp_ready)) state_d = LOAD;
         end
         default: state_d = EMPTY;
      endcase
   end

   assign beat       = load_ready_c && bus.load_valid;
   assign wr_en      = beat && (wr_ptr != FULL);
   assign req_acc    = req_ready_c && bus.req_valid;
   assign enter_load = (state_d == LOAD) && (state_q != LOAD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         wr_ptr     <= '0;
         load_ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (enter_load) begin
            wr_ptr     <= '0;
            load_ovf_q <= 1'b0;
         end else if (beat) begin
            if (wr_en) wr_ptr     <= wr_ptr + PW'(4);
            else       load_ovf_q <= 1'b1;
         end
      end
   end

   // contents deliberately survive reset so a program outlives a core reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < 4; k++) begin
            mem[{wr_ptr[IW-1:2], 2'(k)}] <= BIG_ENDIAN ? bus.load_data[8*(3-k) +: 8]
                                                       : bus.load_data[8*k +: 8];
         end
      end
   end

   assign mis     = bus.req_addr[1:0] != 2'b00;
   assign oor     = bus.req_addr > LAST_ADDR;
   assign rd_widx = (mis || oor) ? '0 : bus.req_addr[IW-1:2];

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < 4; k++) begin
         if (BIG_ENDIAN) rd_word[8*(3-k) +: 8] = mem[{rd_widx, 2'(k)}];
         else            rd_word[8*k +: 8]     = mem[{rd_widx, 2'(k)}];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_instr_q <= NOP_WORD;
         rsp_addr_q  <= '0;
         rsp_err_q   <= 2'b00;
      end else if (req_acc) begin
         rsp_valid_q <= 1'b1;
         rsp_addr_q  <= bus.req_addr;
         rsp_err_q   <= {oor, mis};
         rsp_instr_q <= (mis || oor) ? NOP_WORD : rd_word;
      end else if (bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign bus.load_ready = load_ready_c;
   assign bus.load_ovf   = load_ovf_q;
   assign bus.req_ready  = req_ready_c;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_instr  = rsp_instr_q;
   assign bus.rsp_addr   = rsp_addr_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.state      = state_q;
endmodule

// File: tb/tb_instr_mem_sync.sv
// Drives identical stimulus into big- and little-endian instances and compares
// both against a transaction-level memory model every cycle.
module tb_instr_mem_sync;
   localparam int          MB  = 1024;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_en, load_valid, load_last, req_valid, rsp_ready;
   logic [31:0] load_data, req_addr;

   always #5 clk = ~clk;

   instr_mem_sync_if #(.ADDR_WIDTH(32)) if_be ();
   instr_mem_sync_if #(.ADDR_WIDTH(32)) if_le ();

   assign if_be.load_en = load_en;     assign if_le.load_en = load_en;
   assign if_be.load_valid = load_valid; assign if_le.load_valid = load_valid;
   assign if_be.load_data = load_data; assign if_le.load_data = load_data;
   assign if_be.load_last = load_last; assign if_le.load_last = load_last;
   assign if_be.req_valid = req_valid; assign if_le.req_valid = req_valid;
   assign if_be.req_addr = req_addr;   assign if_le.req_addr = req_addr;
   assign if_be.rsp_ready = rsp_ready; assign if_le.rsp_ready = rsp_ready;

   instr_mem_sync #(.MEM_BYTES(MB), .ADDR_WIDTH(32), .NOP_WORD(NOP), .BIG_ENDIAN(1'b1))
      u_be (.clk(clk), .rst_n(rst_n), .bus(if_be));
   instr_mem_sync #(.MEM_BYTES(MB), .ADDR_WIDTH(32), .NOP_WORD(NOP), .BIG_ENDIAN(1'b0))
      u_le (.clk(clk), .rst_n(rst_n), .bus(if_le));

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: program words as loaded, plus the one outstanding response
   int          m_st, m_wp;
   bit          m_ovf, m_rv, m_rk;
   logic [31:0] m_ri, m_ra;
   logic [1:0]  m_re;
   logic [31:0] m_mem [MB/4];
   bit          m_known [MB/4];

   logic [31:0] prog [3] = '{32'h0045_7820, 32'h202D_0030, 32'h8CC9_0005};
   logic [31:0] ea [4]   = '{32'h6, 32'h3FC, 32'h400, 32'h401};
   logic [1:0]  ee [4]   = '{2'b01, 2'b00, 2'b10, 2'b11};
   logic [31:0] w0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_wp = 0; m_ovf = 0;
      m_rv = 0; m_ri = NOP; m_ra = 0; m_re = 0; m_rk = 1;
   endtask

   task automatic model_step();
      int          nst = m_st;
      bit          acc = (m_st == 2) && !load_en && (!m_rv || rsp_ready) && req_valid;
      logic [31:0] a   = req_addr;
      case (m_st)
         0: if (load_en) nst = 1;
         1: if (load_valid) begin
               if (m_wp >= MB) m_ovf = 1;
               else begin
                  m_mem[m_wp/4] = load_data; m_known[m_wp/4] = 1; m_wp += 4;
               end
               if (load_last) nst = 2;
            end
         default: if (load_en && (!m_rv || rsp_ready)) nst = 1;
      endcase
      if (acc) begin
         m_rv = 1; m_ra = a;
         m_re = {a > 32'(MB - 4), (a % 4) != 0};
         if (m_re != 2'b00) begin m_ri = NOP; m_rk = 1; end
         else begin m_ri = m_mem[a/4]; m_rk = m_known[a/4]; end
      end else if (rsp_ready) m_rv = 0;
      if (nst == 1 && m_st != 1) begin m_wp = 0; m_ovf = 0; end
      m_st = nst;
   endtask

   task automatic check_one(input string p, input logic [1:0] st, input logic lr, lo, qr, rv,
                            input logic [31:0] ri, ra, input logic [1:0] re);
      chk({p, ".state"}, st, m_st);
      chk({p, ".load_ready"}, lr, m_st == 1);
      chk({p, ".load_ovf"}, lo, m_ovf);
      chk({p, ".req_ready"}, qr, (m_st == 2) && !load_en && (!m_rv || rsp_ready));
      chk({p, ".rsp_valid"}, rv, m_rv);
      chk({p, ".rsp_addr"}, ra, m_ra);
      chk({p, ".rsp_err"}, re, m_re);
      if (m_rk) chk({p, ".rsp_instr"}, ri, m_ri);
   endtask

   task automatic check_all();
      check_one("be", if_be.state, if_be.load_ready, if_be.load_ovf, if_be.req_ready,
                if_be.rsp_valid, if_be.rsp_instr, if_be.rsp_addr, if_be.rsp_err);
      check_one("le", if_le.state, if_le.load_ready, if_le.load_ovf, if_le.req_ready,
                if_le.rsp_valid, if_le.rsp_instr, if_le.rsp_addr, if_le.rsp_err);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      load_en = 0; load_valid = 0; load_data = 0; load_last = 0;
      req_valid = 0; req_addr = 0; rsp_ready = 1;
      rst_n = 0; model_reset();
      #2 check_all();
      chk("rst.rsp_instr", if_be.rsp_instr, NOP);
      @(negedge clk); rst_n = 1;
      cycle();

      // program load
      load_en = 1; cycle(); load_en = 0;
      chk("load.state", if_be.state, 32'd1);
      for (int i = 0; i < 3; i++) begin
         load_valid = 1; load_data = prog[i]; load_last = (i == 2); cycle();
      end
      load_valid = 0; load_last = 0;
      chk("run.state", if_be.state, 32'd2);
      chk("be.mem0", u_be.mem[0], 32'h00);
      chk("le.mem0", u_le.mem[0], 32'h20);

      // back-to-back fetches, 1-cycle latency
      for (int i = 0; i < 3; i++) begin
         req_valid = 1; req_addr = 32'(i * 4); cycle();
         chk("fetch.be", if_be.rsp_instr, prog[i]);
         chk("fetch.le", if_le.rsp_instr, prog[i]);
      end
      req_valid = 0; cycle();
      chk("fetch.drain", if_be.rsp_valid, 32'd0);

      // error boundaries
      for (int i = 0; i < 4; i++) begin
         req_valid = 1; req_addr = ea[i]; cycle();
         chk("err.code", if_be.rsp_err, ee[i]);
         chk("err.addr", if_be.rsp_addr, ea[i]);
         if (ee[i] != 2'b00) chk("err.nop", if_be.rsp_instr, NOP);
      end
      req_valid = 0; cycle();

      // stalled consumer
      rsp_ready = 0; req_valid = 1; req_addr = 0; cycle();
      req_addr = 4;
      repeat (3) begin
         cycle();
         chk("stall.addr", if_be.rsp_addr, 32'd0);
         chk("stall.instr", if_be.rsp_instr, prog[0]);
         chk("stall.req_ready", if_be.req_ready, 32'd0);
      end
      rsp_ready = 1; cycle();
      chk("stall.next_addr", if_be.rsp_addr, 32'd4);
      chk("stall.next_instr", if_be.rsp_instr, prog[1]);
      req_valid = 0; cycle();
      chk("stall.no_dup", if_be.rsp_valid, 32'd0);

      // reload requested while a response is stalled
      rsp_ready = 0; req_valid = 1; req_addr = 8; cycle();
      load_en = 1; req_addr = 0;
      repeat (2) begin
         cycle();
         chk("reload.state", if_be.state, 32'd2);
         chk("reload.rsp_addr", if_be.rsp_addr, 32'd8);
         chk("reload.req_ready", if_be.req_ready, 32'd0);
      end
      rsp_ready = 1; cycle();
      chk("reload.to_load", if_be.state, 32'd1);
      chk("reload.wr_ptr", u_be.wr_ptr, 32'd0);
      load_en = 0; req_valid = 0;

      // fill past capacity
      for (int i = 0; i < 258; i++) begin
         load_valid = 1; load_last = (i == 257);
         load_data = (i == 256) ? 32'hBAD0_BAD0 : $urandom;
         if (i == 0) w0 = load_data;
         cycle();
         if (i == 255) chk("ovf.before", if_be.load_ovf, 32'd0);
         if (i == 256) chk("ovf.after", if_be.load_ovf, 32'd1);
      end
      load_valid = 0; load_last = 0;
      req_valid = 1; req_addr = 0; cycle();
      chk("ovf.word0", if_be.rsp_instr, w0);
      req_valid = 0; cycle();

      // randomized fetch traffic over the full memory
      for (int c = 0; c < 600; c++) begin
         req_valid = ($urandom % 4) != 0;
         rsp_ready = ($urandom % 3) != 0;
         case ($urandom % 4)
            0: req_addr = ($urandom % 256) * 4;
            1: req_addr = (($urandom % 256) * 4) | (1 + $urandom % 3);
            2: req_addr = 1016 + $urandom % 16;
            default: req_addr = $urandom;
         endcase
         cycle();
      end
      req_valid = 0; rsp_ready = 1; cycle();

      // async reset mid-load, memory survives
      load_en = 1; cycle(); load_en = 0;
      load_valid = 1; load_data = 32'h1111_1111; cycle();
      load_data = 32'h2222_2222; cycle();
      load_valid = 0;
      #2 rst_n = 0; model_reset();
      #1 check_all();
      chk("arst.state", if_be.state, 32'd0);
      @(negedge clk); rst_n = 1;
      cycle();
      load_en = 1; cycle(); load_en = 0;
      load_valid = 1; load_last = 1; load_data = 32'h3333_3333; cycle();
      load_valid = 0; load_last = 0;
      req_valid = 1; req_addr = 4; cycle();
      chk("keep.addr4", if_be.rsp_instr, 32'h2222_2222);
      req_valid = 0; cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
